// File: rtl/mem_pkg.sv
// Shared memory-subsystem definitions: access FSM states, reset values and
// the saturating statistics increment.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      HOLD   = 2'd3
   } mem_state_e;

   localparam logic       RST_REQ_READY = 1'b1;
   localparam logic       RST_RSP_VALID = 1'b0;
   localparam logic       RST_MEM_WR    = 1'b0;
   localparam logic       RST_MEM_RD    = 1'b0;
   localparam int         STATS_WIDTH   = 16;
   localparam logic [15:0] STATS_MAX    = 16'hFFFF;

   function automatic logic [15:0] sat_inc(input logic [15:0] value);
      if (value == STATS_MAX) begin
         return value;
      end else begin
         return value + 16'd1;
      end
   endfunction

endpackage

// File: rtl/strobe_timer.sv
// Strobe-length down-counter: load presets CYCLES-1, count steps toward zero,
// done is high while the current strobe cycle is the last one.
module strobe_timer #(
   parameter int unsigned CYCLES = 2,
   parameter int unsigned CW     = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic count,
   output logic done
);

   localparam logic [CW-1:0] LOAD_VAL = CW'(CYCLES - 32'd1);

   logic [CW-1:0] r_cnt;

   // Down-counter; holds at zero so done stays asserted until reloaded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (load) begin
         r_cnt <= LOAD_VAL;
      end else if (count && (r_cnt != '0)) begin
         r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign done = (r_cnt == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Program-memory access sequencer: IDLE -> SETUP -> STROBE(xSTROBE_CYCLES) -> HOLD.
// Optional access statistics enabled by defining MEM_ACCESS_CTRL_STATS_EN.
module mem_access_ctrl
   import mem_pkg::*;
#(
   parameter int AWIDTH        = 15,
   parameter int DWIDTH        = 32,
   parameter int STROBE_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [AWIDTH-1:0] req_addr,
   input  logic [DWIDTH-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DWIDTH-1:0] rsp_rdata,
   output logic [AWIDTH-1:0] mem_addr,
   output logic              mem_wr,
   output logic              mem_rd,
   output logic [DWIDTH-1:0] mem_wdata,
   input  logic [DWIDTH-1:0] mem_rdata
`ifdef MEM_ACCESS_CTRL_STATS_EN
   ,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count
`endif
);

   mem_state_e r_state;
   logic       r_we;
   logic       w_load;
   logic       w_count;
   logic       w_done;

   assign w_load  = (r_state == SETUP);
   assign w_count = (r_state == STROBE);

   strobe_timer #(
      .CYCLES (STROBE_CYCLES),
      .CW     (4)
   ) u_strobe_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (w_load),
      .count (w_count),
      .done  (w_done)
   );

   // Access FSM; mem_addr/mem_wdata double as the captured request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_we      <= 1'b0;
         req_ready <= RST_REQ_READY;
         rsp_valid <= RST_RSP_VALID;
         rsp_rdata <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wr    <= RST_MEM_WR;
         mem_rd    <= RST_MEM_RD;
      end else begin
         rsp_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_we      <= req_we;
                  mem_addr  <= req_addr;
                  mem_wdata <= req_wdata;
                  req_ready <= 1'b0;
                  r_state   <= SETUP;
               end else begin
                  req_ready <= 1'b1;
               end
            end
            SETUP: begin
               mem_wr  <= r_we;
               mem_rd  <= ~r_we;
               r_state <= STROBE;
            end
            STROBE: begin
               if (w_done) begin
                  mem_wr    <= 1'b0;
                  mem_rd    <= 1'b0;
                  rsp_valid <= 1'b1;
                  r_state   <= HOLD;
                  if (!r_we) begin
                     rsp_rdata <= mem_rdata;
                  end else begin
                     rsp_rdata <= rsp_rdata;
                  end
               end else begin
                  r_state <= STROBE;
               end
            end
            HOLD: begin
               req_ready <= 1'b1;
               r_state   <= IDLE;
            end
            default: begin
               mem_wr    <= 1'b0;
               mem_rd    <= 1'b0;
               req_ready <= 1'b1;
               r_state   <= IDLE;
            end
         endcase
      end
   end

`ifdef MEM_ACCESS_CTRL_STATS_EN
   // Completed-access counters, bumped once in HOLD and saturating.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_count <= 16'h0000;
         wr_count <= 16'h0000;
      end else if (r_state == HOLD) begin
         if (r_we) begin
            wr_count <= sat_inc(wr_count);
            rd_count <= rd_count;
         end else begin
            rd_count <= sat_inc(rd_count);
            wr_count <= wr_count;
         end
      end else begin
         rd_count <= rd_count;
         wr_count <= wr_count;
      end
   end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: one instance with STROBE_CYCLES=2 on a
// memory model, one with STROBE_CYCLES=3 for strobe-shape checks.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_valid3;
   logic        req_we;
   logic [14:0] req_addr;
   logic [31:0] req_wdata;

   logic        req_ready2, rsp_valid2, mem_wr2, mem_rd2;
   logic [31:0] rsp_rdata2, mem_wdata2, mem_rdata2;
   logic [14:0] mem_addr2;
   logic        req_ready3, rsp_valid3, mem_wr3, mem_rd3;
   logic [31:0] rsp_rdata3, mem_wdata3, mem_rdata3;
   logic [14:0] mem_addr3;
`ifdef MEM_ACCESS_CTRL_STATS_EN
   logic [15:0] rd_count2, wr_count2, rd_count3, wr_count3;
`endif

   logic [31:0] mem2 [0:32767];
   logic        pre_we;
   logic [14:0] pre_addr;
   logic [31:0] pre_data;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_access_ctrl #(.AWIDTH(15), .DWIDTH(32), .STROBE_CYCLES(2)) u_dut2 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready2),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .mem_addr(mem_addr2),
      .mem_wr(mem_wr2), .mem_rd(mem_rd2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2)
`ifdef MEM_ACCESS_CTRL_STATS_EN
      , .rd_count(rd_count2), .wr_count(wr_count2)
`endif
   );

   mem_access_ctrl #(.AWIDTH(15), .DWIDTH(32), .STROBE_CYCLES(3)) u_dut3 (
      .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .mem_addr(mem_addr3),
      .mem_wr(mem_wr3), .mem_rd(mem_rd3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
`ifdef MEM_ACCESS_CTRL_STATS_EN
      , .rd_count(rd_count3), .wr_count(wr_count3)
`endif
   );

   // Memory model: tb presets take priority over DUT writes.
   always @(posedge clk) begin
      if (pre_we) mem2[pre_addr] <= pre_data;
      else if (mem_wr2) mem2[mem_addr2] <= mem_wdata2;
   end
   assign mem_rdata2 = mem_rd2 ? mem2[mem_addr2] : 32'hzzzz_zzzz;
   assign mem_rdata3 = mem_rd3 ? ({17'h0, mem_addr3} ^ 32'hA5A5_0000) : 32'hzzzz_zzzz;

   task automatic preset(input logic [14:0] a, input logic [31:0] d);
      pre_addr = a; pre_data = d; pre_we = 1'b1;
      @(posedge clk); #1;
      pre_we = 1'b0;
   endtask

   // Issue one request to u_dut2; lat counts cycles with SETUP as cycle 1.
   task automatic do_access(input logic we, input logic [14:0] a, input logic [31:0] d,
                            output int lat, output logic [31:0] rdata, output logic overlap);
      int n;
      overlap = 1'b0;
      req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
      n = 0;
      while (!req_ready2 && n < 50) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid2 && lat < 50) begin
         if (mem_wr2 && mem_rd2) overlap = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      rdata = rsp_rdata2;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b0; req_valid3 = 1'b0; req_we = 1'b0;
      req_addr = 15'h0; req_wdata = 32'h0; pre_we = 1'b0; pre_addr = 15'h0; pre_data = 32'h0;
      @(posedge clk); @(posedge clk); #1;
      checks++; if (req_ready2 !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b expected 1", req_ready2); end
      checks++; if (rsp_valid2 !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid2); end
      checks++; if (rsp_rdata2 !== 32'h0) begin failures++; $display("FAIL rst_rdata: got %h expected 0", rsp_rdata2); end
      checks++; if (mem_addr2 !== 15'h0) begin failures++; $display("FAIL rst_addr: got %h expected 0", mem_addr2); end
      checks++; if (mem_wdata2 !== 32'h0) begin failures++; $display("FAIL rst_wdata: got %h expected 0", mem_wdata2); end
      checks++; if ({mem_wr2, mem_rd2} !== 2'b00) begin failures++; $display("FAIL rst_strobes: got %b expected 00", {mem_wr2, mem_rd2}); end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (req_ready2 !== 1'b1) begin failures++; $display("FAIL idle_ready: got %b expected 1", req_ready2); end
   endtask

   task automatic test_write_read();
      int lat; logic [31:0] rd; logic ov;
      do_access(1'b1, 15'h0010, 32'hDEAD_BEEF, lat, rd, ov);
      checks++; if (lat !== 4) begin failures++; $display("FAIL wr_latency: got %0d expected 4", lat); end
      checks++; if (rd !== 32'h0) begin failures++; $display("FAIL wr_keeps_rdata: got %h expected 0", rd); end
      checks++; if (ov !== 1'b0) begin failures++; $display("FAIL wr_overlap: got %b expected 0", ov); end
      checks++; if (mem2[16] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_mem: got %h expected deadbeef", mem2[16]); end
      do_access(1'b0, 15'h0010, 32'h0, lat, rd, ov);
      checks++; if (lat !== 4) begin failures++; $display("FAIL rd_latency: got %0d expected 4", lat); end
      checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
   endtask

   task automatic test_strobe_shape();
      int rd_cnt = 0; int vcyc = 0; logic wr_seen = 1'b0; logic addr_bad = 1'b0;
      logic [5:0] rd_pat = 6'b0;
      checks++; if (req_ready3 !== 1'b1) begin failures++; $display("FAIL s3_ready: got %b expected 1", req_ready3); end
      req_we = 1'b0; req_addr = 15'h0123; req_valid3 = 1'b1;
      @(posedge clk); #1;
      req_valid3 = 1'b0; req_addr = 15'h0777;
      for (int k = 1; k <= 6; k++) begin
         if (mem_rd3) begin rd_cnt++; rd_pat[k-1] = 1'b1; end
         if (mem_wr3) wr_seen = 1'b1;
         if (k <= 5 && mem_addr3 !== 15'h0123) addr_bad = 1'b1;
         if (rsp_valid3) vcyc = k;
         @(posedge clk); #1;
      end
      checks++; if (rd_cnt !== 3) begin failures++; $display("FAIL s3_rd_cycles: got %0d expected 3", rd_cnt); end
      checks++; if (rd_pat !== 6'b001110) begin failures++; $display("FAIL s3_rd_shape: got %b expected 001110", rd_pat); end
      checks++; if (wr_seen !== 1'b0) begin failures++; $display("FAIL s3_wr_seen: got %b expected 0", wr_seen); end
      checks++; if (addr_bad !== 1'b0) begin failures++; $display("FAIL s3_addr_stable: got %b expected 0", addr_bad); end
      checks++; if (vcyc !== 5) begin failures++; $display("FAIL s3_rsp_cycle: got %0d expected 5", vcyc); end
      checks++; if (rsp_rdata3 !== 32'hA5A5_0123) begin failures++; $display("FAIL s3_rdata: got %h expected a5a50123", rsp_rdata3); end
   endtask

   task automatic test_backpressure();
      int lat; logic ready_bad = 1'b0; logic addr_bad = 1'b0; logic [31:0] first_rd = 32'h0;
      preset(15'h0100, 32'h1111_0100);
      preset(15'h0205, 32'h2222_0205);
      req_we = 1'b0; req_addr = 15'h0100; req_valid = 1'b1;
      @(posedge clk); #1;
      for (int k = 1; k <= 5; k++) begin
         req_addr = 15'h0200 + 15'(k);
         if (k < 5) begin
            if (req_ready2 !== 1'b0) ready_bad = 1'b1;
            if (mem_addr2 !== 15'h0100) addr_bad = 1'b1;
         end
         if (k == 4) first_rd = rsp_rdata2;
         if (k == 5) begin
            checks++; if (req_ready2 !== 1'b1) begin failures++; $display("FAIL bp_reaccept: got %b expected 1", req_ready2); end
         end
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      checks++; if (ready_bad !== 1'b0) begin failures++; $display("FAIL bp_ready_low: got %b expected 0", ready_bad); end
      checks++; if (addr_bad !== 1'b0) begin failures++; $display("FAIL bp_addr_held: got %b expected 0", addr_bad); end
      checks++; if (first_rd !== 32'h1111_0100) begin failures++; $display("FAIL bp_first_data: got %h expected 11110100", first_rd); end
      checks++; if (mem_addr2 !== 15'h0205) begin failures++; $display("FAIL bp_second_addr: got %h expected 0205", mem_addr2); end
      lat = 1;
      while (!rsp_valid2 && lat < 50) begin @(posedge clk); #1; lat++; end
      checks++; if (rsp_rdata2 !== 32'h2222_0205) begin failures++; $display("FAIL bp_second_data: got %h expected 22220205", rsp_rdata2); end
      @(posedge clk); #1;
   endtask

   task automatic test_boundary();
      int lat; logic [31:0] rd; logic ov;
      preset(15'h7FFF, 32'h1234_5678);
      preset(15'h0000, 32'hCAFE_F00D);
      do_access(1'b0, 15'h7FFF, 32'h0, lat, rd, ov);
      checks++; if (rd !== 32'h1234_5678) begin failures++; $display("FAIL bnd_rd_top: got %h expected 12345678", rd); end
      do_access(1'b0, 15'h0000, 32'h0, lat, rd, ov);
      checks++; if (rd !== 32'hCAFE_F00D) begin failures++; $display("FAIL bnd_rd_zero: got %h expected cafef00d", rd); end
      do_access(1'b1, 15'h7FFF, 32'h0BAD_0BAD, lat, rd, ov);
      checks++; if (rd !== 32'hCAFE_F00D) begin failures++; $display("FAIL bnd_wr_keeps_rdata: got %h expected cafef00d", rd); end
      checks++; if (mem2[32767] !== 32'h0BAD_0BAD) begin failures++; $display("FAIL bnd_wr_top: got %h expected 0bad0bad", mem2[32767]); end
      do_access(1'b0, 15'h7FFF, 32'h0, lat, rd, ov);
      checks++; if (rd !== 32'h0BAD_0BAD) begin failures++; $display("FAIL bnd_rd_back: got %h expected 0bad0bad", rd); end
   endtask

   task automatic test_reset_mid_strobe();
      logic seen = 1'b0;
      req_we = 1'b0; req_addr = 15'h0055; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++; if (mem_rd2 !== 1'b1) begin failures++; $display("FAIL mid_rd_before: got %b expected 1", mem_rd2); end
      rst = 1'b1;
      #1;
      checks++; if (mem_rd2 !== 1'b0) begin failures++; $display("FAIL mid_rd_drop: got %b expected 0", mem_rd2); end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (rsp_valid2) seen = 1'b1;
         @(posedge clk); #1;
      end
      checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mid_no_rsp: got %b expected 0", seen); end
      checks++; if (req_ready2 !== 1'b1) begin failures++; $display("FAIL mid_ready: got %b expected 1", req_ready2); end
      checks++; if (rsp_rdata2 !== 32'h0) begin failures++; $display("FAIL mid_rdata: got %h expected 0", rsp_rdata2); end
   endtask

`ifdef MEM_ACCESS_CTRL_STATS_EN
   task automatic test_stats();
      int lat; logic [31:0] rd; logic ov;
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0; @(posedge clk); #1;
      for (int i = 0; i < 3; i++) do_access(1'b0, 15'h0010, 32'h0, lat, rd, ov);
      for (int i = 0; i < 2; i++) do_access(1'b1, 15'h0020, 32'h5, lat, rd, ov);
      checks++; if (rd_count2 !== 16'd3) begin failures++; $display("FAIL st_rd_count: got %0d expected 3", rd_count2); end
      checks++; if (wr_count2 !== 16'd2) begin failures++; $display("FAIL st_wr_count: got %0d expected 2", wr_count2); end
      force u_dut2.rd_count = 16'hFFFF;
      @(posedge clk); #1;
      release u_dut2.rd_count;
      do_access(1'b0, 15'h0010, 32'h0, lat, rd, ov);
      checks++; if (rd_count2 !== 16'hFFFF) begin failures++; $display("FAIL st_saturate: got %h expected ffff", rd_count2); end
      checks++; if (wr_count2 !== 16'd2) begin failures++; $display("FAIL st_wr_hold: got %0d expected 2", wr_count2); end
   endtask
`endif

   initial begin
      test_reset();
      test_write_read();
      test_strobe_shape();
      test_backpressure();
      test_boundary();
      test_reset_mid_strobe();
`ifdef MEM_ACCESS_CTRL_STATS_EN
      test_stats();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter AWIDTH, default 15, memory address width.
REQ-002 SHALL have parameter DWIDTH, default 32, memory data width.
REQ-003 SHALL have parameter STROBE_CYCLES, default 2, cycles wr/rd stays high per access (legal range 1..15).
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  access request.
REQ-007 SHALL have port req_ready  output  1  request accepted when high together with req_valid.
REQ-008 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-009 SHALL have port req_addr  input  AWIDTH  target address.
REQ-010 SHALL have port req_wdata  input  DWIDTH  write data.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata  output  DWIDTH  read data; holds its value until the next read completes.
REQ-013 SHALL have ports mem_addr  output  AWIDTH, mem_wr  output  1, mem_rd  output  1, mem_wdata  output  DWIDTH: drive the program memory.
REQ-014 SHALL have port mem_rdata  input  DWIDTH  memory data out, high-Z when mem_rd is low.

Function
REQ-015 SHALL implement FSM states IDLE, SETUP, STROBE, HOLD.
REQ-016 SHALL assert req_ready only in IDLE.
REQ-017 On an accepting edge, SHALL register req_we, req_addr and req_wdata and go to SETUP; later changes on req_* SHALL be ignored until IDLE.
REQ-018 In SETUP (1 cycle), SHALL drive mem_addr/mem_wdata from the registered request with mem_wr=mem_rd=0, then go to STROBE.
REQ-019 In STROBE, SHALL hold exactly one of mem_wr (write) or mem_rd (read) high for STROBE_CYCLES cycles, using a down-counter; mem_addr/mem_wdata SHALL remain stable.
REQ-020 For reads, SHALL capture mem_rdata into rsp_rdata on the clock edge that ends the last STROBE cycle.
REQ-021 In HOLD (1 cycle), SHALL drive mem_wr=mem_rd=0, keep mem_addr stable, assert rsp_valid, then return to IDLE.
REQ-022 mem_wr and mem_rd SHALL be driven by registers, glitch-free, and never high simultaneously.
REQ-023 Latency: for a request accepted at edge T, rsp_valid SHALL be high during cycle T+STROBE_CYCLES+2; throughput SHALL be one access per STROBE_CYCLES+3 cycles.
REQ-024 rsp_valid SHALL pulse for writes too; rsp_rdata SHALL be unchanged by writes.
REQ-025 A request presented while busy SHALL remain pending (ready low) and be accepted in the next IDLE cycle.
REQ-026 Addresses 0 and 2**AWIDTH-1 SHALL be passed unmodified; there is no address arithmetic.

Reset
REQ-027 While rst is high, SHALL set the state to IDLE and drive req_ready=1, rsp_valid=0, rsp_rdata=0, mem_addr=0, mem_wdata=0, mem_wr=0 and mem_rd=0, independent of clk.
REQ-028 Reset during STROBE SHALL drop the strobe immediately, discard the access and produce no rsp_valid.

Configuration
REQ-029 With MEM_ACCESS_CTRL_STATS_EN defined, SHALL add outputs rd_count and wr_count (16 bits each, reset 0), each incremented once per completed access in HOLD and saturating at 16'hFFFF.
REQ-030 Without MEM_ACCESS_CTRL_STATS_EN, SHALL omit these ports and counters, with all other behaviour identical.

Structure
REQ-031 The FSM state enum and the reset constants SHALL reside in shared package mem_pkg, reused by the memory subsystem.
REQ-032 The strobe-length down-counter SHALL be the sub-module strobe_timer (load, count, done).

Verification
REQ-033 Write then read: write addr 0x0010 data 0xDEADBEEF, then read 0x0010 -> rsp_rdata=0xDEADBEEF with rsp_valid 4 cycles after acceptance (STROBE_CYCLES=2).
REQ-034 Strobe shape: STROBE_CYCLES=3 read -> mem_rd high exactly 3 cycles, mem_addr stable from SETUP through HOLD, mem_wr never high.
REQ-035 Backpressure: req_valid held high with a changing req_addr during a busy access -> req_ready low and only the address present at acceptance reaches mem_addr; the next request is accepted 5 cycles after the first.
REQ-036 Boundary: read at 0x7FFF and at 0x0000 -> correct data for both; a write leaves rsp_rdata unchanged.
REQ-037 Reset mid-STROBE: assert rst in cycle 2 of the strobe -> mem_rd=0 immediately, no rsp_valid, req_ready=1 after rst is released.
REQ-038 Stats (macro defined): 3 reads and 2 writes -> rd_count=3 and wr_count=2; forcing a counter to 0xFFFF then performing one more access -> it stays at 0xFFFF.
